bn_res_pipe: RTL and testbench

Parametrised successor of the per-layer batch-norm/residual stage. Per channel it computes y = sat(relu?((a*x >>> FRAC_SHIFT) + b + res)). It uses a 2-stage pipeline with valid/ready backpressure, internally held BN parameters written through a config port, and a saturation-event counter. It sits between the macro accumulator outputs and the next layer's input buffer, and is reusable for every layer through its parameters.

---
 rtl/bn_res_pkg.sv | 35 +++
 rtl/bn_res_lane.sv | 72 +++++++
 rtl/bn_res_pipe.sv | 115 +++++++++++
 tb/tb_bn_res_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_res_pkg.sv
// Shared constants and the output saturation helper for the batch-norm/residual pipeline.
package bn_res_pkg;

  localparam logic MODE_RELOAD    = 1'b0;
  localparam logic MODE_CALCULATE = 1'b1;
  localparam logic CFG_SEL_A      = 1'b0;
  localparam logic CFG_SEL_B      = 1'b1;

  // Wide enough for any PARA_W+DATA_W+2 sum used in practice.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] val;
    logic                    clip;
  } sat_t;

  function automatic sat_t sat_to_dw(input logic signed [SAT_W-1:0] sum, input int dw);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_t                    r;
    max_v  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v  = -max_v - 64'sd1;
    r.val  = sum;
    r.clip = 1'b0;
    if (sum > max_v) begin
      r.val  = max_v;
      r.clip = 1'b1;
    end else if (sum < min_v) begin
      r.val  = min_v;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bn_res_lane.sv
// One channel: full-precision multiply in stage 1, shift/add/saturate/ReLU into the
// registered output in stage 2.
module bn_res_lane
  import bn_res_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int PARA_W     = 16,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ld_p1,
  input  logic                     i_ld_p2,
  input  logic                     i_relu_p1,
  input  logic signed [PARA_W-1:0] i_a,
  input  logic signed [PARA_W-1:0] i_b,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_res,
  input  logic                     i_res_en,
  output logic signed [DATA_W-1:0] o_y,
  output logic                     o_clip
);

  localparam int PROD_W = PARA_W + DATA_W;
  localparam int SUM_W  = PROD_W + 2;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod_p1;
  logic signed [PROD_W-1:0] w_prod_sh;
  logic signed [PARA_W-1:0] r_b_p1;
  logic signed [DATA_W-1:0] r_res_p1;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_y;
  logic signed [DATA_W-1:0] r_y_p2;
  sat_t                     w_sat;
  logic                     w_unused_hi;

  assign w_prod = $signed({{DATA_W{i_a[PARA_W-1]}}, i_a}) *
                  $signed({{PARA_W{i_x[DATA_W-1]}}, i_x});

  // Stage 1: capture the full-precision product and both addends
  always_ff @(posedge clk) begin
    if (i_ld_p1) begin
      r_prod_p1 <= w_prod;
      r_b_p1    <= i_b;
      r_res_p1  <= i_res_en ? i_res : '0;
    end
  end

  assign w_prod_sh = r_prod_p1 >>> FRAC_SHIFT;
  assign w_sum = $signed({{2{w_prod_sh[PROD_W-1]}}, w_prod_sh})
               + $signed({{(SUM_W-PARA_W){r_b_p1[PARA_W-1]}}, r_b_p1})
               + $signed({{(SUM_W-DATA_W){r_res_p1[DATA_W-1]}}, r_res_p1});
  assign w_sat = sat_to_dw($signed({{(SAT_W-SUM_W){w_sum[SUM_W-1]}}, w_sum}), DATA_W);

  // Clip flag is taken before ReLU so clamped negatives still count as saturation.
  assign w_y         = (i_relu_p1 && w_sat.val[DATA_W-1]) ? '0 : w_sat.val[DATA_W-1:0];
  assign o_clip      = w_sat.clip;
  assign w_unused_hi = ^w_sat.val[SAT_W-1:DATA_W];

  // Stage 2: registered result, held while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_p2 <= '0;
    end else if (i_ld_p2) begin
      r_y_p2 <= w_y;
    end
  end

  assign o_y = r_y_p2;

endmodule

// File: rtl/bn_res_pipe.sv
// Batch-norm + residual stage: per-channel y = sat(relu?((a*x >>> FRAC_SHIFT) + b + res)),
// two-stage pipeline with valid/ready, config-written a/b, and a saturation event counter.
module bn_res_pipe
  import bn_res_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int PARA_W     = 16,
  parameter int CH_NUM     = 512,
  parameter int RES_DEPTH  = 256,
  parameter int FRAC_SHIFT = 8,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         cfg_we,
  input  logic                         cfg_sel,
  input  logic [$clog2(CH_NUM)-1:0]    cfg_addr,
  input  logic signed [PARA_W-1:0]     cfg_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_W-1:0]     data_in [CH_NUM],
  input  logic signed [DATA_W-1:0]     res_in [RES_DEPTH],
  input  logic                         res_en,
  input  logic                         relu_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_W-1:0]     data_out [CH_NUM],
  output logic [CNT_W-1:0]             sat_cnt
);

  localparam int                       AW     = $clog2(CH_NUM);
  localparam int                       AW1    = AW + 1;
  localparam logic [AW:0]              CH_LIM = AW1'(CH_NUM);
  localparam logic signed [PARA_W-1:0] A_ONE  = PARA_W'(1 << FRAC_SHIFT);

  logic signed [PARA_W-1:0] r_a [CH_NUM];
  logic signed [PARA_W-1:0] r_b [CH_NUM];
  logic                     r_vld_p1;
  logic                     r_vld_p2;
  logic                     r_relu_p1;
  logic [CNT_W-1:0]         r_sat_cnt;
  logic [CH_NUM-1:0]        w_clip;
  logic                     w_adv;
  logic                     w_xfer;
  logic                     w_ld_p2;
  logic                     w_cfg_wr;

  assign w_adv    = !r_vld_p2 || out_ready;
  assign in_ready = w_adv && (mode == MODE_CALCULATE);
  assign w_xfer   = in_valid && in_ready;
  assign w_ld_p2  = w_adv && r_vld_p1;
  assign w_cfg_wr = (mode == MODE_RELOAD) && cfg_we && ({1'b0, cfg_addr} < CH_LIM);

  // Parameters captured by stage 1 at transfer, so later writes never touch in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_a[i] <= A_ONE;
        r_b[i] <= '0;
      end
    end else if (w_cfg_wr) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (cfg_addr == AW'(i)) begin
          if (cfg_sel == CFG_SEL_A) r_a[i] <= cfg_data;
          else                      r_b[i] <= cfg_data;
        end
      end
    end
  end

  // Stage 1 / stage 2 control: both valids and the counter advance together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_sat_cnt <= '0;
    end else if (w_adv) begin
      r_vld_p1 <= w_xfer;
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1 && (|w_clip) && (r_sat_cnt != '1)) begin
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) r_relu_p1 <= relu_en;
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
    bn_res_lane #(
      .DATA_W     (DATA_W),
      .PARA_W     (PARA_W),
      .FRAC_SHIFT (FRAC_SHIFT)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_ld_p1   (w_xfer),
      .i_ld_p2   (w_ld_p2),
      .i_relu_p1 (r_relu_p1),
      .i_a       (r_a[g]),
      .i_b       (r_b[g]),
      .i_x       (data_in[g]),
      .i_res     (res_in[g % RES_DEPTH]),
      .i_res_en  (res_en),
      .o_y       (data_out[g]),
      .o_clip    (w_clip[g])
    );
  end

  assign out_valid = r_vld_p2;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_bn_res_pipe.sv
// Directed bench for bn_res_pipe (4 channels, residual depth 2, 4-bit counter) with an
// arithmetic reference model checked on every output cycle.
module tb_bn_res_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic               cfg_we;
  logic               cfg_sel;
  logic [1:0]         cfg_addr;
  logic signed [15:0] cfg_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] data_in [4];
  logic signed [15:0] res_in [2];
  logic               res_en;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] data_out [4];
  logic [3:0]         sat_cnt;

  bn_res_pipe #(
    .DATA_W(16), .PARA_W(16), .CH_NUM(4), .RES_DEPTH(2), .FRAC_SHIFT(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .res_in(res_in), .res_en(res_en), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] y;
    logic [3:0]       cnt;
  } exp_t;

  exp_t q[$];
  int   m_a [4];
  int   m_b [4];
  int   m_cnt;
  int   n_out = 0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected vectors queued at transfer, compared while on the output.
  always @(negedge clk) begin : model_p
    exp_t   e;
    longint s;
    logic   any;
    if (rst) begin
      q.delete();
      m_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        m_a[i] = 256;
        m_b[i] = 0;
      end
    end else begin
      chk("in_ready", longint'(in_ready), longint'((!out_valid || out_ready) && mode));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", longint'(out_valid), 0);
        end else begin
          for (int i = 0; i < 4; i++)
            chk($sformatf("data_out[%0d]", i), longint'(data_out[i]),
                longint'($signed(q[0].y[i])));
          chk("sat_cnt", longint'(sat_cnt), longint'(q[0].cnt));
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
          s = (longint'(m_a[i]) * longint'(data_in[i])) >>> 8;
          s = s + longint'(m_b[i]);
          if (res_en) s = s + longint'(res_in[i % 2]);
          if (s > 32767) begin
            s = 32767;
            any = 1'b1;
          end else if (s < -32768) begin
            s = -32768;
            any = 1'b1;
          end
          if (relu_en && s < 0) s = 0;
          e.y[i] = s[15:0];
        end
        if (any && m_cnt < 15) m_cnt++;
        e.cnt = 4'(m_cnt);
        q.push_back(e);
      end
      if (!mode && cfg_we) begin
        if (cfg_sel) m_b[cfg_addr] = int'(cfg_data);
        else         m_a[cfg_addr] = int'(cfg_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int x0, x1, x2, x3, input int r0, r1, input bit ren, relu);
    data_in[0] = 16'(x0);
    data_in[1] = 16'(x1);
    data_in[2] = 16'(x2);
    data_in[3] = 16'(x3);
    res_in[0]  = 16'(r0);
    res_in[1]  = 16'(r1);
    res_en     = ren;
    relu_en    = relu;
  endtask

  task automatic send(input int x0, x1, x2, x3, input int r0, r1, input bit ren, relu);
    int n;
    setv(x0, x1, x2, x3, r0, r1, ren, relu);
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_accepted", longint'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("wait_out_valid", longint'(out_valid), 1);
  endtask

  task automatic cfg(input bit sel, input int addr, input int val);
    mode     = 1'b0;
    cfg_sel  = sel;
    cfg_addr = 2'(addr);
    cfg_data = 16'(val);
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, k, c;
    rst = 1'b1; mode = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    setv(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sat_cnt", longint'(sat_cnt), 0);
    chk("rst_data_out0", longint'(data_out[0]), 0);
    rst = 1'b0;

    // 1: identity parameters
    send(100, -50, 0, 7, 0, 0, 1'b0, 1'b0);
    wait_out();
    chk("t1_ch0", longint'(data_out[0]), 100);
    chk("t1_ch1", longint'(data_out[1]), -50);
    chk("t1_ch3", longint'(data_out[3]), 7);
    chk("t1_sat", longint'(sat_cnt), 0);

    // 2: a[1]=2.0, b[1]=5, residual on
    cfg(1'b0, 1, 16'h0200);
    cfg(1'b1, 1, 5);
    mode = 1'b1;
    send(11, 1000, 22, 33, 4, -3, 1'b1, 1'b0);
    wait_out();
    chk("t2_ch0", longint'(data_out[0]), 15);
    chk("t2_ch1", longint'(data_out[1]), 2002);
    chk("t2_ch3", longint'(data_out[3]), 30);

    // 3: saturation in both directions and counter stick
    cfg(1'b0, 0, 16'h7FFF);
    mode = 1'b1;
    send(32767, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    wait_out();
    chk("t3_pos_sat", longint'(data_out[0]), 32767);
    chk("t3_cnt1", longint'(sat_cnt), 1);
    send(-32767, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    wait_out();
    chk("t3_neg_sat", longint'(data_out[0]), -32768);
    chk("t3_cnt2", longint'(sat_cnt), 2);
    for (int i = 0; i < 20; i++) send(32767, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("t3_cnt_stick", longint'(sat_cnt), 15);

    // 4: stream of 6 with a 3-cycle output stall
    cfg(1'b0, 0, 16'h0100);
    mode = 1'b1;
    n0 = n_out; k = 0; c = 0;
    while (k < 6 && c < 40) begin
      out_ready = !(c >= 3 && c <= 5);
      setv(100 * k - 150, 7 * k, -3 * k, k, 0, 0, 1'b0, 1'b0);
      in_valid = 1'b1;
      #1;
      if (c >= 3 && c <= 5) chk("t4_stall_in_ready", longint'(in_ready), 0);
      if (in_ready) k++;
      tick();
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("t4_delivered", longint'(n_out - n0), 6);

    // 5: ReLU, with and without clipping (counter cleared by reset)
    rst = 1'b1; tick(); rst = 1'b0;
    send(-300, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    wait_out();
    chk("t5_relu", longint'(data_out[0]), 0);
    chk("t5_cnt0", longint'(sat_cnt), 0);
    send(-32768, 0, 0, 0, -7232, 0, 1'b1, 1'b1);
    wait_out();
    chk("t5_relu_clip", longint'(data_out[0]), 0);
    chk("t5_relu_res", longint'(data_out[2]), 0);
    chk("t5_cnt1", longint'(sat_cnt), 1);

    // 6a: config write ignored in calculate mode
    mode = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd2; cfg_data = '0; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    send(1, 2, 123, 4, 0, 0, 1'b0, 1'b0);
    wait_out();
    chk("t6_cfg_ignored", longint'(data_out[2]), 123);

    // 6b: switch to reload with two vectors in flight
    tick();
    out_ready = 1'b0;
    n0 = n_out;
    send(10, 11, 12, 13, 0, 0, 1'b0, 1'b0);
    send(20, 21, 22, 23, 0, 0, 1'b0, 1'b0);
    mode = 1'b0;
    setv(99, 99, 99, 99, 0, 0, 1'b0, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("t6_reload_in_ready", longint'(in_ready), 0);
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    chk("t6_drained", longint'(n_out - n0), 2);
    chk("t6_idle", longint'(out_valid), 0);

    // 6c: reset during a stall restores identity parameters
    cfg(1'b0, 3, 16'h0300);
    mode = 1'b1; out_ready = 1'b0;
    send(1, 1, 1, 1, 0, 0, 1'b0, 1'b0);
    wait_out();
    rst = 1'b1;
    tick();
    chk("t6_rst_out_valid", longint'(out_valid), 0);
    chk("t6_rst_data", longint'(data_out[0]), 0);
    rst = 1'b0; out_ready = 1'b1;
    send(0, 0, 0, 50, 0, 0, 1'b0, 1'b0);
    wait_out();
    chk("t6_rst_identity", longint'(data_out[3]), 50);
    tick(); tick();
    chk("leftover_expected", longint'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
